// File: rtl/gfx_bank_arbiter.sv
// -----------------------------------------------------------------------------
// gfx_bank_arbiter
//
// Shares one video-memory bank read port between four graphics fetch
// requesters (0=sprite, 1=bg0, 2=bg1, 3=overlay) with round-robin priority.
// One word read is in flight at a time; the fetched word is returned on the
// shared REQ_DATA bus together with a one-cycle REQ_READYg pulse to the
// granted requester g.
//
// Optional feature macro: GFX_BANK_ARB_TIMEOUT_EN
//   defined   : a watchdog aborts a bank read that has not completed after
//               TIMEOUT BUSY cycles, returns 0 and sets the sticky ERR flag.
//   undefined : BUSY waits indefinitely, ERR is tied low, ERR_CLR is unused.
//
// Ports
//   CLK, RSTb            clock (rising edge), async active-low reset
//   REQ_ADDR0..3         requester read addresses
//   REQ_VALID0..3        requester read requests
//   REQ_READY0..3        one-cycle data-valid pulse to the granted requester
//   REQ_DATA             returned word, shared by all requesters
//   B_ADDR, B_VALID      bank request (address = low bits of granted address)
//   B_DIN, B_READY       bank read data and its data-valid pulse
//   ERR, ERR_CLR         sticky watchdog timeout flag and its clear
// -----------------------------------------------------------------------------
module gfx_bank_arbiter #(
   parameter int BITS              = 16,
   parameter int ADDRESS_BITS      = 16,
   parameter int BANK_ADDRESS_BITS = 14,
   parameter int TIMEOUT           = 64
) (
   input  logic                         CLK,
   input  logic                         RSTb,
   input  logic [ADDRESS_BITS-1:0]      REQ_ADDR0,
   input  logic [ADDRESS_BITS-1:0]      REQ_ADDR1,
   input  logic [ADDRESS_BITS-1:0]      REQ_ADDR2,
   input  logic [ADDRESS_BITS-1:0]      REQ_ADDR3,
   input  logic                         REQ_VALID0,
   input  logic                         REQ_VALID1,
   input  logic                         REQ_VALID2,
   input  logic                         REQ_VALID3,
   output logic                         REQ_READY0,
   output logic                         REQ_READY1,
   output logic                         REQ_READY2,
   output logic                         REQ_READY3,
   output logic [BITS-1:0]              REQ_DATA,
   output logic [BANK_ADDRESS_BITS-1:0] B_ADDR,
   output logic                         B_VALID,
   input  logic [BITS-1:0]              B_DIN,
   input  logic                         B_READY,
   output logic                         ERR,
   input  logic                         ERR_CLR
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [1:0]                     r_ptr;
   logic [1:0]                     r_g;
   logic [BANK_ADDRESS_BITS-1:0]   r_b_addr;
   logic [BITS-1:0]                r_data;
   logic [3:0]                     w_valid;
   logic [ADDRESS_BITS-1:0]        w_addr [4];
   logic                           w_any;
   logic [1:0]                     w_win;
   logic                           w_timeout;
   logic [3:0]                     w_ready;
   logic                           w_unused_ok;

   assign w_valid   = {REQ_VALID3, REQ_VALID2, REQ_VALID1, REQ_VALID0};
   assign w_addr[0] = REQ_ADDR0;
   assign w_addr[1] = REQ_ADDR1;
   assign w_addr[2] = REQ_ADDR2;
   assign w_addr[3] = REQ_ADDR3;
   assign w_any     = |w_valid;

   // Upper requester address bits are never forwarded to the bank.
   assign w_unused_ok = ^{REQ_ADDR0, REQ_ADDR1, REQ_ADDR2, REQ_ADDR3, ERR_CLR};

   // Round-robin search starting at r_ptr. Offsets are visited from the
   // farthest to the nearest so the nearest requesting index wins.
   always_comb begin
      logic [1:0] idx;
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      w_win = r_ptr;
      idx   = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = r_ptr + 2'(k);
         if (w_valid[idx]) begin
            w_win = idx;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_BUSY;
         S_BUSY:  if (B_READY || w_timeout) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      B_VALID = (r_state == S_BUSY);
      w_ready = '0;
      if (r_state == S_RESP) begin
         w_ready[r_g] = 1'b1;
      end
   end

   assign REQ_READY0 = w_ready[0];
   assign REQ_READY1 = w_ready[1];
   assign REQ_READY2 = w_ready[2];
   assign REQ_READY3 = w_ready[3];

   // ----------------------------------------------------------- datapath
   // Address is captured at grant time so requester changes during BUSY
   // cannot disturb the bank request. B_READY outside BUSY is ignored.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_ptr    <= 2'd0;
         r_g      <= 2'd0;
         r_b_addr <= '0;
         r_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_g      <= w_win;
                  r_ptr    <= w_win + 2'd1;
                  r_b_addr <= w_addr[w_win][BANK_ADDRESS_BITS-1:0];
               end
            end
            S_BUSY: begin
               if (B_READY) begin
                  r_data <= B_DIN;
               end else if (w_timeout) begin
                  r_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign B_ADDR   = r_b_addr;
   assign REQ_DATA = r_data;

`ifdef GFX_BANK_ARB_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_err;

   // A completing B_READY in the last count cycle beats the abort.
   assign w_timeout = (r_state == S_BUSY) && !B_READY &&
                      (r_wd_cnt == WD_W'(TIMEOUT - 1));

   // Counter is held at 0 outside BUSY, so it starts from 0 on BUSY entry.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == S_BUSY) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end else begin
            r_wd_cnt <= '0;
         end
         // A new timeout wins over a simultaneous clear.
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (ERR_CLR) begin
            r_err <= 1'b0;
         end
      end
   end

   assign ERR = r_err;
`else
   assign w_timeout = 1'b0;
   assign ERR       = 1'b0;
`endif

endmodule
